// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative HI/LO divider: state encoding, cycle count
// and the HI/LO write-enable encoding (01 = LO, 10 = HI, 11 = both).
package div_iter_pkg;

  localparam int DIV_CYCLES = 32;

  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
// Combinational, zero latency, no flow control.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = neg ? (~val + WIDTH'(1)) : val;
  end

endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU feeding HI (remainder) and LO (quotient).
// done pulses WIDTH+1 cycles after start; busy stalls the pipe, start is only taken in IDLE.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       hilo_we
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

  logic             dvnd_neg, dvsr_neg, dz_in;
  logic [WIDTH-1:0] dvnd_abs, dvsr_abs;
  logic [WIDTH:0]   shl;
  logic             take;
  logic [WIDTH-1:0] diff, quo_step, rem_step, quo_fix, rem_fix;

  always_comb begin
    dvnd_neg = is_signed & dividend[WIDTH-1];
    dvsr_neg = is_signed & divisor[WIDTH-1];
    dz_in    = (divisor == '0);
  end

  // A zero divisor keeps the raw dividend so the remainder path shifts it back out unchanged.
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvnd (.val(dividend), .neg(dvnd_neg & ~dz_in), .res(dvnd_abs));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvsr (.val(divisor),  .neg(dvsr_neg),          .res(dvsr_abs));

  always_comb begin
    shl      = {rem_q, quo_q[WIDTH-1]};
    take     = (shl >= {1'b0, dvsr_q});
    diff     = shl[WIDTH-1:0] - dvsr_q;
    quo_step = {quo_q[WIDTH-2:0], take};
    rem_step = take ? diff : shl[WIDTH-1:0];
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val(quo_step), .neg(negq_q & ~dz_q), .res(quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val(rem_step), .neg(negr_q & ~dz_q), .res(rem_fix));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d = ST_DIV;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = dvnd_abs;
          dvsr_d  = dvsr_abs;
          negq_d  = dvnd_neg ^ dvsr_neg;
          negr_d  = dvnd_neg;
          dz_d    = dz_in;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A flush landing on the DONE cycle suppresses the HI/LO write.
  always_comb begin
    busy    = (state_q == ST_DIV);
    done    = (state_q == ST_DONE) && !flush;
    hilo_we = done ? HILO_WE_BOTH : HILO_WE_NONE;
    hi_out  = hi_q;
    lo_out  = lo_q;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Iterative radix-2 restoring integer divider for MIPS DIV/DIVU, one quotient bit per cycle.
It sits in the execute stage, directly upstream of the HI/LO register pair.
- Quotient is driven on lo_out and remainder on hi_out.
- A one-cycle hilo_we = 2'b11 pulse writes both registers.
- The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (the only supported value for MIPS; kept for the bench's reduced-width runs).

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request a divide; accepted only in IDLE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
flush  input  1  abort in-flight divide (exception/branch cancel)
dividend  input  WIDTH  rs operand, sampled with start
divisor  input  WIDTH  rt operand, sampled with start
busy  output  1  high while a divide is in flight (DIV state)
done  output  1  one-cycle pulse, results valid
hi_out  output  WIDTH  remainder, held until next done
lo_out  output  WIDTH  quotient, held until next done
hilo_we  output  2  2'b11 during done cycle, else 2'b00

Behaviour:
- Reset (resetn = 0 at an edge, any state): state IDLE, busy = 0, done = 0, hilo_we = 2'b00, hi_out = 0, lo_out = 0, counter = 0. This includes reset mid-divide.
- States:
  - IDLE: start & !flush -> DIV. Latch |dividend| and |divisor| (abs only if is_signed), latch sign flags, clear the partial remainder, counter = 0.
  - DIV: one iteration per edge.
    - Shift {rem, quo} left by 1.
    - If shifted rem >= divisor_abs, subtract and set quo LSB = 1.
    - counter increments; after the WIDTH-th iteration -> DONE.
    - The result registers are updated on that same edge.
  - DONE: done = 1, hilo_we = 2'b11, busy = 0 for exactly one cycle; unconditionally -> IDLE.
- Latency: start sampled at edge E0; done is high in the cycle following edge E0 + WIDTH, i.e. WIDTH + 1 cycles after the start cycle. Back-to-back: the next start is accepted in the cycle after done.
- busy is high in every DIV cycle. The start cycle itself is not busy, so the pipeline must gate start on !busy & !done.
- Sign correction, applied when writing results:
  - Quotient negated iff is_signed and the operand signs differ.
  - Remainder negated iff is_signed and dividend is negative.
- Divisor = 0: no trap; the algorithm runs the full latency.
  - lo_out = all-ones; hi_out = dividend as given, no sign correction applied to either.
  - This case is detected at start and stored in a flag.
- Signed overflow 0x80000000 / -1: lo_out = 0x80000000, hi_out = 0. This falls out of the abs/negate path and needs no special case.
- flush: in DIV or DONE -> IDLE on next edge.
  - done and hilo_we are forced low in that cycle if flush is high during DONE.
  - hi_out/lo_out keep their previous values.
- start asserted in DIV or DONE: ignored, not queued.
- flush & start together in IDLE: flush wins, stay IDLE.
- Operands may change after the start cycle; all inputs except flush are ignored outside IDLE.

Decomposition:
- Shared package: state encoding (IDLE/DIV/DONE, 2-bit), DIV_CYCLES = WIDTH, HILO_WE_NONE = 2'b00, HILO_WE_BOTH = 2'b11 (common with the HI/LO write-enable encoding 01 = LO, 10 = HI, 11 = both).
- One sub-module, div_sign_fix: combinational conditional two's-complement negate (input value, negate flag -> output). It is instanced for operand abs and for quotient/remainder correction.

Test Plan:
- Unsigned 100 / 7, start one cycle -> done in cycle E0 + 33, lo_out = 14, hi_out = 2, hilo_we = 2'b11 for exactly one cycle, busy high for 32 cycles.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF; signed 7 / -2 -> lo_out = 0xFFFFFFFD, hi_out = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0; unsigned same operands -> lo_out = 0, hi_out = 0x80000000.
- Divide by zero, unsigned 5 / 0 and signed -5 / 0 -> lo_out = 0xFFFFFFFF, hi_out = 5 / 0xFFFFFFFB, full latency.
- Flush at 10th DIV cycle -> IDLE next cycle, busy = 0, no done/hilo_we pulse, prior results unchanged. A new start 2 cycles later completes normally.
- Start pulsed during DIV -> ignored (single done). resetn low mid-DIV -> all outputs 0 next cycle, no done.
